imem_loader: RTL

Program loader for the 64-word instruction memory. Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Writes each word through the memory's data-side write port (`ram_a`, `d_t_ram`, `wram`) while holding the CPU in reset. It is the writer for the port the memory exposes for reading, so software images can be replaced without resynthesis.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory: assembles big-endian words
// and writes them while holding the CPU in reset. Optional trailing XOR byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] ram_a,
    output logic [31:0] d_t_ram,
    output logic        wram,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [IW-1:0]  r_idx;
    logic [IW-1:0]  r_last;
    logic [1:0]     r_bcnt;
    logic [23:0]    r_word;
    logic [31:0]    r_ram_a;
    logic [31:0]    r_d_t_ram;
    logic           w_hs;
    logic           w_hdr_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]     r_xor;
    logic           r_err;
`endif

    // Control outputs are pure decodes of the registered state.
    assign rx_ready = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
    assign wram     = (r_state == S_WRITE);
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign cpu_hold = busy;
    assign done     = (r_state == S_DONE);
    assign ram_a    = r_ram_a;
    assign d_t_ram  = r_d_t_ram;
    assign w_hs     = rx_valid && rx_ready;
    // A zero header or any count beyond the memory loads the whole memory.
    assign w_hdr_full = (rx_data == 8'd0) || ({1'b0, rx_data} > 9'(DEPTH));
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_HDR : S_IDLE;
            S_HDR:   w_next = w_hs ? S_DATA : S_HDR;
            S_DATA:  w_next = (w_hs && (r_bcnt == 2'd3)) ? S_WRITE : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_WRITE: w_next = (r_idx == r_last) ? S_CSUM : S_DATA;
            S_CSUM:  w_next = w_hs ? S_DONE : S_CSUM;
`else
            S_WRITE: w_next = (r_idx == r_last) ? S_DONE : S_DATA;
`endif
            S_DONE:  w_next = start ? S_HDR : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: header latch, byte assembly, write address/data capture, checksum.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_idx     <= '0;
            r_last    <= '0;
            r_bcnt    <= 2'd0;
            r_word    <= 24'd0;
            r_ram_a   <= 32'd0;
            r_d_t_ram <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= 8'd0;
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_HDR: begin
                    if (w_hs) begin
                        r_last <= w_hdr_full ? IW'(DEPTH - 1) : IW'(rx_data - 8'd1);
                        r_idx  <= '0;
                        r_bcnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor  <= 8'd0;
`endif
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        r_word <= {r_word[15:0], rx_data};
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor  <= r_xor ^ rx_data;
`endif
                        // Address/data are captured with the 4th byte so they are valid in WRITE.
                        if (r_bcnt == 2'd3) begin
                            r_ram_a   <= {{(30 - IW){1'b0}}, r_idx, 2'b00};
                            r_d_t_ram <= {r_word, rx_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_idx <= r_idx + IW'(1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_hs) begin
                        r_err <= (rx_data != r_xor);
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
